// File: rtl/fu_seq.sv
// Multicycle function unit: single-cycle ALU/shift ops plus iterative unsigned multiply and divide.
// Latency is 1 cycle for ALU/shift ops and WIDTH+2 cycles for MUL/DIV. start is only honoured in IDLE.
module fu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FS,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z,
    output logic             DZ
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, EXEC, ITER, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, f_q, f_d;
    logic [4:0]       fs_q, fs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             prep_q, prep_d, done_q, done_d;
    logic             v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d, dz_q, dz_d;

    logic [SHW-1:0]   k, neg_k;
    logic [WIDTH-1:0] op2, alu_f, div_diff, res_f;
    logic [WIDTH:0]   sum, mul_sum, div_sh;
    logic             cin, is_arith, alu_c, alu_v, div_ge, res_c, res_v, res_dz;

    assign k     = a_q[SHW-1:0];
    assign neg_k = -k;

    always_comb begin
        op2      = '0;
        cin      = 1'b0;
        is_arith = 1'b0;
        case (fs_q[3:0])
            4'd0: begin op2 = b_q;  is_arith = 1'b1; end
            4'd1: begin op2 = ~b_q; cin = 1'b1; is_arith = 1'b1; end
            4'd6: begin cin = 1'b1; is_arith = 1'b1; end
            default: ;
        endcase
    end

    assign sum   = {1'b0, a_q} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
    assign alu_c = is_arith & sum[WIDTH];
    assign alu_v = is_arith & (a_q[WIDTH-1] == op2[WIDTH-1]) & (sum[WIDTH-1] != a_q[WIDTH-1]);

    // Rotates use a modulo-WIDTH complementary shift so k=0 leaves B untouched.
    always_comb begin
        alu_f = b_q;
        case (fs_q[3:0])
            4'd0, 4'd1, 4'd6: alu_f = sum[WIDTH-1:0];
            4'd2:  alu_f = a_q & b_q;
            4'd3:  alu_f = a_q | b_q;
            4'd4:  alu_f = a_q ^ b_q;
            4'd5:  alu_f = ~a_q;
            4'd7:  alu_f = a_q;
            4'd8:  alu_f = b_q << k;
            4'd9:  alu_f = b_q >> k;
            4'd10: alu_f = $signed(b_q) >>> k;
            4'd11: alu_f = (b_q << k) | (b_q >> neg_k);
            4'd12: alu_f = (b_q >> k) | (b_q << neg_k);
            default: alu_f = b_q;
        endcase
    end

    // hi/lo hold {accumulator, multiplier} for MUL and {remainder, quotient} for DIV.
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign div_sh   = {hi_q, lo_q[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, b_q};
    assign div_diff = div_sh[WIDTH-1:0] - b_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fs_d    = fs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        prep_d  = prep_q;
        done_d  = 1'b0;
        f_d     = f_q;
        v_d     = v_q;
        c_d     = c_q;
        n_d     = n_q;
        z_d     = z_q;
        dz_d    = dz_q;
        res_f   = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_dz  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d  = A;
                    b_d  = B;
                    fs_d = FS;
                    if (FS[4] && !(FS[3] || FS[2])) begin
                        state_d = ITER;
                        cnt_d   = CW'(WIDTH);
                        prep_d  = 1'b1;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (!fs_q[4]) begin
                    res_f = alu_f;
                    res_c = alu_c;
                    res_v = alu_v;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ITER: begin
                if (prep_q) begin
                    hi_d   = '0;
                    lo_d   = fs_q[1] ? a_q : b_q;
                    prep_d = 1'b0;
                end else begin
                    if (fs_q[1]) begin
                        hi_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = FIN;
                end
            end
            FIN: begin
                res_f   = fs_q[0] ? hi_q : lo_q;
                res_dz  = fs_q[1] & (b_q == '0);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (done_d) begin
            f_d  = res_f;
            v_d  = res_v;
            c_d  = res_c;
            dz_d = res_dz;
            n_d  = res_f[WIDTH-1];
            z_d  = (res_f == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fs_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            prep_q  <= 1'b0;
            done_q  <= 1'b0;
            f_q     <= '0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fs_q    <= fs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            prep_q  <= prep_d;
            done_q  <= done_d;
            f_q     <= f_d;
            v_q     <= v_d;
            c_q     <= c_d;
            n_q     <= n_d;
            z_q     <= z_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign F    = f_q;
    assign V    = v_q;
    assign C    = c_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign DZ   = dz_q;
endmodule

// File: tb/tb_fu_seq.sv
// Bench for fu_seq at WIDTH 8, 32 and 64 against an arithmetic reference model.
module tb_fu_seq;
    typedef struct {
        logic [63:0] f;
        logic        v, c, n, z, dz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic signed [127:0] sext(input logic [63:0] x, input int w);
        logic signed [127:0] r;
        r = $signed({64'b0, x});
        if (x[w-1]) r = r - (128'sd1 <<< w);
        return r;
    endfunction

    function automatic exp_t zero_res();
        exp_t e;
        e.f = '0; e.v = 0; e.c = 0; e.n = 0; e.z = 0; e.dz = 0; e.lat = 0;
        return e;
    endfunction

    // Result of one operation at width w, straight from the arithmetic definitions.
    function automatic exp_t model(input int w, input logic [4:0] fs,
                                   input logic [63:0] a_in, input logic [63:0] b_in);
        exp_t e;
        logic [63:0] mask, a, b;
        logic [127:0] p;
        logic signed [127:0] s, lim;
        int k;
        e    = zero_res();
        mask = (64'd1 << w) - 64'd1;
        a    = a_in & mask;
        b    = b_in & mask;
        k    = int'(a % 64'(w));
        lim  = 128'sd1 <<< (w - 1);
        s    = '0;
        p    = {64'b0, a} * {64'b0, b};
        e.lat = (fs[4] && fs[3:2] == 2'b00) ? w + 2 : 1;
        case (fs)
            5'd0: begin
                s = sext(a, w) + sext(b, w);
                e.f = (a + b) & mask;
                e.c = ({64'b0, a} + {64'b0, b}) > {64'b0, mask};
                e.v = (s >= lim) || (s < -lim);
            end
            5'd1: begin
                s = sext(a, w) - sext(b, w);
                e.f = (a - b) & mask;
                e.c = (a >= b);
                e.v = (s >= lim) || (s < -lim);
            end
            5'd2: e.f = a & b;
            5'd3: e.f = a | b;
            5'd4: e.f = a ^ b;
            5'd5: e.f = ~a & mask;
            5'd6: begin
                s = sext(a, w) + 1;
                e.f = (a + 1) & mask;
                e.c = (a == mask);
                e.v = (s >= lim);
            end
            5'd7:  e.f = a;
            5'd8:  e.f = (b << k) & mask;
            5'd9:  e.f = b >> k;
            5'd10: e.f = 64'(sext(b, w) >>> k) & mask;
            5'd11: e.f = ((b << k) | (b >> (w - k))) & mask;
            5'd12: e.f = ((b >> k) | (b << (w - k))) & mask;
            5'd13, 5'd14, 5'd15: e.f = b;
            5'd16: e.f = p[63:0] & mask;
            5'd17: e.f = 64'(p >> w) & mask;
            5'd18: begin e.f = (b == 0) ? mask : a / b; e.dz = (b == 0); end
            5'd19: begin e.f = (b == 0) ? a : a % b;    e.dz = (b == 0); end
            default: e.f = '0;
        endcase
        e.n = e.f[w-1];
        e.z = (e.f == 0);
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom % 8)
            0: return 64'd0;
            1: return '1;
            2: return 64'($urandom % 16);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [4:0] pick_fs();
        if ($urandom % 2 == 0) return 5'(16 + $urandom % 4);
        return 5'($urandom % 32);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : gw
        localparam int W = (gi == 0) ? 8 : (gi == 1) ? 32 : 64;
        logic rst, start, busy, done, V, C, N, Z, DZ;
        logic [W-1:0] A, B, F;
        logic [4:0] FS;
        int   rem = 0;
        exp_t pend, cur;
        logic e_done = 1'b0;
        bit   fin = 1'b0;

        fu_seq #(.WIDTH(W)) dut (
            .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .FS(FS),
            .busy(busy), .done(done), .F(F), .V(V), .C(C), .N(N), .Z(Z), .DZ(DZ)
        );

        // Reference timeline: an accepted op completes lat edges later; nothing is accepted meanwhile.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                rem = 0;
                e_done = 1'b0;
                cur = zero_res();
            end else begin
                e_done = 1'b0;
                if (rem > 0) begin
                    rem--;
                    if (rem == 0) begin
                        cur = pend;
                        e_done = 1'b1;
                    end
                end else if (start) begin
                    pend = model(W, FS, 64'(A), 64'(B));
                    rem  = pend.lat;
                end
            end
        end

        always @(negedge clk) begin
            check($sformatf("W%0d busy", W), 64'(busy), 64'(rem > 0));
            check($sformatf("W%0d done", W), 64'(done), 64'(e_done));
            check($sformatf("W%0d F", W), 64'(F), cur.f);
            check($sformatf("W%0d VCNZ", W), 64'({V, C, N, Z}), 64'({cur.v, cur.c, cur.n, cur.z}));
            check($sformatf("W%0d DZ", W), 64'(DZ), 64'(cur.dz));
        end

        initial begin
            logic [4:0]   dfs[14];
            logic [W-1:0] da[14], db[14], ones, msb, pat;
            bit hold;
            ones = '1;
            msb  = ones ^ (ones >> 1);
            pat  = W'(64'hA5C3_0F96_1234_5678);
            dfs[0]  = 5'd16; da[0]  = W'(7);   db[0]  = W'(9);
            dfs[1]  = 5'd0;  da[1]  = ones >> 1; db[1] = W'(1);
            dfs[2]  = 5'd1;  da[2]  = W'(5);   db[2]  = W'(5);
            dfs[3]  = 5'd10; da[3]  = W'(W - 1); db[3] = msb;
            dfs[4]  = 5'd12; da[4]  = W'(1);   db[4]  = W'(1);
            dfs[5]  = 5'd11; da[5]  = W'(64'h40); db[5] = pat;
            dfs[6]  = 5'd6;  da[6]  = ones >> 1; db[6] = pat;
            dfs[7]  = 5'd21; da[7]  = pat;     db[7]  = pat;
            dfs[8]  = 5'd16; da[8]  = ones;    db[8]  = ones;
            dfs[9]  = 5'd17; da[9]  = ones;    db[9]  = ones;
            dfs[10] = 5'd18; da[10] = W'(100); db[10] = W'(7);
            dfs[11] = 5'd19; da[11] = W'(100); db[11] = W'(7);
            dfs[12] = 5'd18; da[12] = pat;     db[12] = '0;
            dfs[13] = 5'd19; da[13] = W'(55);  db[13] = '0;

            rst = 1'b1; start = 1'b0; A = '0; B = '0; FS = '0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;

            // Reset in the middle of a multiply.
            @(posedge clk); #1;
            start = 1'b1; FS = 5'd16; A = W'(7); B = W'(9);
            @(posedge clk); #1;
            start = 1'b0;
            repeat (4) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;

            for (int i = 0; i < 14; i++) begin
                int t;
                @(posedge clk); #1;
                start = 1'b1; FS = dfs[i]; A = da[i]; B = db[i];
                @(posedge clk); #1;
                start = 1'b0; FS = pick_fs(); A = W'(rnd64()); B = W'(rnd64());
                t = 0;
                while (rem != 0 && t < 200) begin
                    @(posedge clk); #1;
                    t++;
                end
                check($sformatf("W%0d op %0d completes", W, i), 64'(rem), 64'd0);
            end

            hold = 1'b0;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                @(posedge clk); #1;
                if (cyc % 150 == 0) hold = ~hold;
                start = hold ? 1'b1 : ($urandom % 4 == 0);
                FS = pick_fs();
                A  = W'(rnd64());
                B  = W'(rnd64());
            end
            @(posedge clk); #1 start = 1'b0;
            fin = 1'b1;
        end
    end

    initial begin
        exp_t e;
        int t;
        e = model(32, 5'd0, 64'h7FFFFFFF, 64'd1);
        check("model add ovf F", e.f, 64'h80000000);
        check("model add ovf VCNZ", 64'({e.v, e.c, e.n, e.z}), 64'b1010);
        e = model(32, 5'd1, 64'd5, 64'd5);
        check("model sub eq CZ", 64'({e.c, e.z, e.f[31:0]}), {30'd0, 2'b11, 32'd0});
        e = model(32, 5'd10, 64'd31, 64'h80000000);
        check("model sra", e.f, 64'hFFFFFFFF);
        e = model(32, 5'd12, 64'd1, 64'd1);
        check("model ror", e.f, 64'h80000000);
        e = model(32, 5'd16, 64'hFFFFFFFF, 64'hFFFFFFFF);
        check("model mull", e.f, 64'h1);
        check("model mul latency", 64'(e.lat), 64'd34);
        e = model(32, 5'd17, 64'hFFFFFFFF, 64'hFFFFFFFF);
        check("model mulh", e.f, 64'hFFFFFFFE);
        e = model(32, 5'd18, 64'd100, 64'd7);
        check("model divu", e.f, 64'd14);
        e = model(32, 5'd19, 64'd100, 64'd7);
        check("model remu", e.f, 64'd2);
        e = model(32, 5'd18, 64'd100, 64'd0);
        check("model divu by 0", 64'({e.dz, e.f[31:0]}), {31'd0, 1'b1, 32'hFFFFFFFF});
        e = model(32, 5'd19, 64'd55, 64'd0);
        check("model remu by 0", 64'({e.dz, e.f[31:0]}), {31'd0, 1'b1, 32'd55});
        e = model(8, 5'd17, 64'hFF, 64'hFF);
        check("model mulh w8", e.f, 64'hFE);
        e = model(64, 5'd17, '1, '1);
        check("model mulh w64", e.f, 64'hFFFFFFFFFFFFFFFE);

        t = 0;
        while (!(gw[0].fin && gw[1].fin && gw[2].fin) && t < 30000) begin
            @(posedge clk);
            t++;
        end
        check("stimulus finished", 64'(gw[0].fin && gw[1].fin && gw[2].fin), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
